// File: rtl/cpu_ctrl_pkg.sv
// Shared types and constants for the multi-cycle CPU control unit.
package cpu_ctrl_pkg;

    typedef enum logic [3:0] {
        OP_NOP   = 4'h0,
        OP_ADD   = 4'h1,
        OP_SUB   = 4'h2,
        OP_AND   = 4'h3,
        OP_OR    = 4'h4,
        OP_XOR   = 4'h5,
        OP_MOV   = 4'h6,
        OP_LDI   = 4'h7,
        OP_LD    = 4'h8,
        OP_ST    = 4'h9,
        OP_JZ    = 4'hA,
        OP_JMP   = 4'hB,
        OP_ILL_C = 4'hC,
        OP_ILL_D = 4'hD,
        OP_ILL_E = 4'hE,
        OP_HALT  = 4'hF
    } opcode_t;

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        HALT   = 3'd5
    } state_t;

    // Register-file input mux select
    localparam logic [1:0] WB_ALU = 2'b00;
    localparam logic [1:0] WB_MEM = 2'b01;
    localparam logic [1:0] WB_REG = 2'b10;
    localparam logic [1:0] WB_IMM = 2'b11;

    // ALU operation codes
    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_AND = 3'd2;
    localparam logic [2:0] ALU_OR  = 3'd3;
    localparam logic [2:0] ALU_XOR = 3'd4;

    // Instruction register field positions
    localparam int OPC_MSB = 15;
    localparam int OPC_LSB = 12;
    localparam int RD_MSB  = 11;
    localparam int RD_LSB  = 10;
    localparam int RS_MSB  = 9;
    localparam int RS_LSB  = 8;
    localparam int IMM_MSB = 7;
    localparam int IMM_LSB = 0;

endpackage

// File: rtl/cpu_ctrl_instr_decoder.sv
// Combinational opcode classifier feeding the control FSM.
module instr_decoder
    import cpu_ctrl_pkg::*;
(
    input  opcode_t    opcode,
    output logic [2:0] alu_op,
    output logic [1:0] wb_sel,
    output logic       writes_reg,
    output logic       is_mem,
    output logic       is_store,
    output logic       is_jump,
    output logic       is_halt,
    output logic       is_illegal
);

    // Map each opcode to its class flags; unlisted flags stay 0
    always_comb begin
        alu_op     = ALU_ADD;
        wb_sel     = WB_ALU;
        writes_reg = 1'b0;
        is_mem     = 1'b0;
        is_store   = 1'b0;
        is_jump    = 1'b0;
        is_halt    = 1'b0;
        is_illegal = 1'b0;
        case (opcode)
            OP_ADD:  begin alu_op = ALU_ADD; writes_reg = 1'b1; end
            OP_SUB:  begin alu_op = ALU_SUB; writes_reg = 1'b1; end
            OP_AND:  begin alu_op = ALU_AND; writes_reg = 1'b1; end
            OP_OR:   begin alu_op = ALU_OR;  writes_reg = 1'b1; end
            OP_XOR:  begin alu_op = ALU_XOR; writes_reg = 1'b1; end
            OP_MOV:  begin wb_sel = WB_REG;  writes_reg = 1'b1; end
            OP_LDI:  begin wb_sel = WB_IMM;  writes_reg = 1'b1; end
            OP_LD:   begin wb_sel = WB_MEM;  writes_reg = 1'b1; is_mem = 1'b1; end
            OP_ST:   begin is_mem = 1'b1; is_store = 1'b1; end
            OP_JZ:   is_jump = 1'b1;
            OP_JMP:  is_jump = 1'b1;
            OP_HALT: is_halt = 1'b1;
            OP_ILL_C, OP_ILL_D, OP_ILL_E: is_illegal = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/cpu_ctrl_fsm.sv
// Multi-cycle control unit: FETCH -> DECODE -> EXEC -> (MEM) -> (WB).
//
// Handshakes: a request (if_req / dmem_req) is raised and held while the FSM
// waits; the matching ready input completes the access in the cycle where it
// is high together with the request. Ready inputs are ignored in any cycle
// where the corresponding request is low.
//
// After reset one quiet cycle follows (settle) in which every output is 0 and
// no fetch is accepted, so an access in flight is dropped cleanly.
module cpu_ctrl_fsm
    import cpu_ctrl_pkg::*;
#(
    parameter int IW = 16,
    parameter int RA = 2
)
(
    input  logic          clk,
    input  logic          reset,
    input  logic [IW-1:0] instr_in,
    output logic          if_req,
    input  logic          if_ready,
    input  logic          zero_flag,
    output logic          dmem_req,
    output logic          dmem_we,
    input  logic          dmem_ready,
    output logic [2:0]    alu_op,
    output logic [1:0]    wb_sel,
    output logic          reg_we,
    output logic [RA-1:0] rd_addr,
    output logic [RA-1:0] rs_addr,
    output logic [7:0]    imm_out,
    output logic          pc_inc,
    output logic          pc_load,
    output logic          halted,
    output logic          illegal
);

    state_t        state;
    state_t        state_next;
    logic [IW-1:0] ir;
    logic          illegal_q;
    logic          settle;
    opcode_t       opcode;

    logic [2:0]    dec_alu_op;
    logic [1:0]    dec_wb_sel;
    logic          dec_writes_reg;
    logic          dec_is_mem;
    logic          dec_is_store;
    logic          dec_is_jump;
    logic          dec_is_halt;
    logic          dec_is_illegal;

    assign opcode  = opcode_t'(ir[OPC_MSB:OPC_LSB]);
    assign illegal = illegal_q;

    instr_decoder u_dec (
        .opcode     (opcode),
        .alu_op     (dec_alu_op),
        .wb_sel     (dec_wb_sel),
        .writes_reg (dec_writes_reg),
        .is_mem     (dec_is_mem),
        .is_store   (dec_is_store),
        .is_jump    (dec_is_jump),
        .is_halt    (dec_is_halt),
        .is_illegal (dec_is_illegal)
    );

    // State, instruction register, sticky illegal flag and post-reset settle
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= FETCH;
            ir        <= '0;
            illegal_q <= 1'b0;
            settle    <= 1'b1;
        end else begin
            state  <= state_next;
            settle <= 1'b0;
            if (state == FETCH && if_ready && !settle)
                ir <= instr_in;
            if (state == DECODE && dec_is_illegal)
                illegal_q <= 1'b1;
        end
    end

    // Next-state and output decode; everything is quiet during settle
    always_comb begin
        state_next = state;
        if_req     = 1'b0;
        dmem_req   = 1'b0;
        dmem_we    = 1'b0;
        alu_op     = ALU_ADD;
        wb_sel     = WB_ALU;
        reg_we     = 1'b0;
        rd_addr    = '0;
        rs_addr    = '0;
        imm_out    = '0;
        pc_inc     = 1'b0;
        pc_load    = 1'b0;
        halted     = 1'b0;
        if (!settle) begin
            case (state)
                FETCH: begin
                    if_req = 1'b1;
                    if (if_ready)
                        state_next = DECODE;
                end
                DECODE: begin
                    rd_addr    = ir[RD_MSB:RD_LSB];
                    rs_addr    = ir[RS_MSB:RS_LSB];
                    imm_out    = ir[IMM_MSB:IMM_LSB];
                    state_next = EXEC;
                end
                EXEC: begin
                    rd_addr = ir[RD_MSB:RD_LSB];
                    rs_addr = ir[RS_MSB:RS_LSB];
                    imm_out = ir[IMM_MSB:IMM_LSB];
                    alu_op  = dec_alu_op;
                    wb_sel  = dec_wb_sel;
                    if (dec_is_halt) begin
                        state_next = HALT;
                    end else if (dec_is_mem) begin
                        state_next = MEM;
                    end else if (dec_writes_reg) begin
                        state_next = WB;
                    end else if (dec_is_jump) begin
                        if (opcode == OP_JZ) begin
                            pc_load = zero_flag;
                            pc_inc  = !zero_flag;
                        end else begin
                            pc_load = 1'b1;
                        end
                        state_next = FETCH;
                    end else begin
                        // NOP and illegal opcodes just advance the PC
                        pc_inc     = 1'b1;
                        state_next = FETCH;
                    end
                end
                MEM: begin
                    rd_addr  = ir[RD_MSB:RD_LSB];
                    rs_addr  = ir[RS_MSB:RS_LSB];
                    imm_out  = ir[IMM_MSB:IMM_LSB];
                    alu_op   = dec_alu_op;
                    wb_sel   = dec_wb_sel;
                    dmem_req = 1'b1;
                    dmem_we  = dec_is_store;
                    if (dmem_ready) begin
                        if (dec_is_store) begin
                            pc_inc     = 1'b1;
                            state_next = FETCH;
                        end else begin
                            state_next = WB;
                        end
                    end
                end
                WB: begin
                    rd_addr    = ir[RD_MSB:RD_LSB];
                    rs_addr    = ir[RS_MSB:RS_LSB];
                    imm_out    = ir[IMM_MSB:IMM_LSB];
                    alu_op     = dec_alu_op;
                    wb_sel     = dec_wb_sel;
                    reg_we     = 1'b1;
                    pc_inc     = 1'b1;
                    state_next = FETCH;
                end
                HALT: begin
                    halted = 1'b1;
                end
                default: state_next = FETCH;
            endcase
        end
    end

endmodule
